// File: rtl/uart_rx_digit_pkg.sv
// Shared definitions for the UART digit receiver: ASCII bounds, FSM state codes
// and the decoded-digit record.
package uart_rx_digit_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  typedef struct packed {
    logic       hit;
    logic [3:0] value;
  } digit_t;

  // 'A'..'F' or 'a'..'f'
  function automatic logic is_hex_letter(input logic [7:0] b);
    return ((b >= ASCII_UA) && (b <= ASCII_UA + 8'd5)) ||
           ((b >= ASCII_LA) && (b <= ASCII_LA + 8'd5));
  endfunction

endpackage

// File: rtl/uart_rx_digit_if.sv
// Result bundle of the UART digit receiver: accepted digit with toggle strobe,
// raw received byte and per-frame status pulses.
interface uart_rx_digit_if;
  import uart_rx_digit_pkg::*;

  logic [3:0] digit_data;
  logic       digit_strobe;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  modport master (output digit_data, output digit_strobe, output rx_byte,
                  output byte_valid, output frame_err);
  modport slave  (input digit_data, input digit_strobe, input rx_byte,
                  input byte_valid, input frame_err);
endinterface

// File: rtl/uart_rx_digit_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle level (1).
module uart_rx_digit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_digit.sv
// 8N1 UART receiver that forwards ASCII decimal digits as value + toggle strobe.
// Define HEX_DIGIT_EN to also accept 'A'-'F' / 'a'-'f' as digits 10..15.
module uart_rx_digit
  import uart_rx_digit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rx_in,
  uart_rx_digit_if.master dig
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [3:0]       digit_data;
  logic             digit_strobe;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;
  digit_t           dec;

  function automatic digit_t decode_digit(input logic [7:0] b);
    digit_t d;
    d.hit   = 1'b0;
    d.value = 4'd0;
    if ((b >= ASCII_0) && (b <= ASCII_9)) begin
      d.hit   = 1'b1;
      d.value = b[3:0];
    end
`ifdef HEX_DIGIT_EN
    else if (is_hex_letter(b)) begin
      // low nibble of 'A'/'a' is 1, so +9 maps the letters onto 10..15
      d.hit   = 1'b1;
      d.value = b[3:0] + 4'd9;
    end
`endif
    return d;
  endfunction

  uart_rx_digit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (uart_rx_in),
    .dout (rx_s)
  );

  assign dec = decode_digit(shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      digit_data   <= '0;
      digit_strobe <= 1'b0;
      rx_byte      <= '0;
      byte_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          // mid-start-bit check rejects short low glitches
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
              if (dec.hit) begin
                digit_data   <= dec.value;
                digit_strobe <= ~digit_strobe;
              end
              state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign dig.digit_data   = digit_data;
  assign dig.digit_strobe = digit_strobe;
  assign dig.rx_byte      = rx_byte;
  assign dig.byte_valid   = byte_valid;
  assign dig.frame_err    = frame_err;

endmodule

// File: tb/tb_uart_rx_digit.sv
// Self-checking bench for uart_rx_digit: serial frames against an ASCII-level reference model.
module tb_uart_rx_digit;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;

  uart_rx_digit_if dig ();

  uart_rx_digit #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx_in (line),
    .dig        (dig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observed events
  logic [7:0] got_bytes[$];
  logic [3:0] got_digits[$];
  int         got_ferr = 0;
  logic       last_strobe = 1'b0;

  // reference model state
  logic [7:0] exp_bytes[$];
  logic [3:0] exp_digits[$];
  int         exp_ferr = 0;
  logic       exp_strobe = 1'b0;
  logic [3:0] exp_digit = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      last_strobe = 1'b0;
    end else begin
      if (dig.byte_valid) got_bytes.push_back(dig.rx_byte);
      if (dig.frame_err) got_ferr++;
      if (dig.digit_strobe !== last_strobe) begin
        got_digits.push_back(dig.digit_data);
        last_strobe = dig.digit_strobe;
      end
    end
  end

  // ASCII character -> digit value, or -1 for a non-digit
  function automatic int ascii_value(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
`ifdef HEX_DIGIT_EN
    if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
    if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
`endif
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good);
    int v;
    if (!good) begin
      exp_ferr++;
      return;
    end
    exp_bytes.push_back(b);
    v = ascii_value(b);
    if (v >= 0) begin
      exp_digits.push_back(v[3:0]);
      exp_strobe = ~exp_strobe;
      exp_digit  = v[3:0];
    end
  endtask

  task automatic clear_obs();
    got_bytes.delete();
    got_digits.delete();
    got_ferr = 0;
    exp_bytes.delete();
    exp_digits.delete();
    exp_ferr = 0;
  endtask

  // Drive one 8N1 frame; called and returns on a negedge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop_ok;
    repeat (CPB + (stop_ok ? 0 : hold_low)) @(negedge clk);
    line = 1'b1;
    model_frame(b, stop_ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dig.digit_data !== 4'd0)   begin errors++; $display("FAIL reset_digit_data got %0h want 0", dig.digit_data); end
    checks++; if (dig.digit_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b want 0", dig.digit_strobe); end
    checks++; if (dig.rx_byte !== 8'h00)     begin errors++; $display("FAIL reset_rx_byte got %0h want 0", dig.rx_byte); end
    checks++; if (dig.byte_valid !== 1'b0)   begin errors++; $display("FAIL reset_byte_valid got %0b want 0", dig.byte_valid); end
    checks++; if (dig.frame_err !== 1'b0)    begin errors++; $display("FAIL reset_frame_err got %0b want 0", dig.frame_err); end
    rst = 1'b0;
    exp_strobe = 1'b0;
    exp_digit  = 4'd0;
    repeat (2 * CPB) @(negedge clk);
    clear_obs();
  endtask

  task automatic test_single_digit();
    clear_obs();
    send_frame(8'h35, 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (got_bytes.size() !== 1 || got_bytes[0] !== 8'h35) begin errors++; $display("FAIL digit5_byte got n=%0d want 35", got_bytes.size()); end
    checks++; if (dig.digit_data !== 4'd5) begin errors++; $display("FAIL digit5_data got %0h want 5", dig.digit_data); end
    checks++; if (dig.digit_strobe !== 1'b1) begin errors++; $display("FAIL digit5_strobe got %0b want 1", dig.digit_strobe); end
    checks++; if (got_digits.size() !== exp_digits.size()) begin errors++; $display("FAIL digit5_events got %0d want %0d", got_digits.size(), exp_digits.size()); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame("1", 1'b1, 0);
    send_frame("2", 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (got_digits.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got_digits.size()); end
    else begin
      checks++; if (got_digits[0] !== 4'd1 || got_digits[1] !== 4'd2) begin errors++; $display("FAIL b2b_order got %0h,%0h want 1,2", got_digits[0], got_digits[1]); end
    end
    checks++; if (dig.digit_data !== exp_digit) begin errors++; $display("FAIL b2b_data got %0h want %0h", dig.digit_data, exp_digit); end
    checks++; if (dig.digit_strobe !== exp_strobe) begin errors++; $display("FAIL b2b_strobe got %0b want %0b", dig.digit_strobe, exp_strobe); end
  endtask

  task automatic test_hex_letter();
    clear_obs();
    send_frame(8'h41, 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (got_bytes.size() !== 1 || got_bytes[0] !== 8'h41) begin errors++; $display("FAIL hexA_byte got n=%0d want 41", got_bytes.size()); end
    checks++; if (got_digits.size() !== exp_digits.size()) begin errors++; $display("FAIL hexA_events got %0d want %0d", got_digits.size(), exp_digits.size()); end
    checks++; if (dig.digit_data !== exp_digit) begin errors++; $display("FAIL hexA_data got %0h want %0h", dig.digit_data, exp_digit); end
    checks++; if (dig.digit_strobe !== exp_strobe) begin errors++; $display("FAIL hexA_strobe got %0b want %0b", dig.digit_strobe, exp_strobe); end
  endtask

  task automatic test_glitch();
    clear_obs();
    line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (got_bytes.size() !== 0 || got_ferr !== 0 || got_digits.size() !== 0) begin
      errors++; $display("FAIL glitch_events got bytes=%0d ferr=%0d digits=%0d want 0", got_bytes.size(), got_ferr, got_digits.size());
    end
    send_frame("8", 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (got_bytes.size() !== 1 || dig.digit_data !== 4'd8) begin errors++; $display("FAIL glitch_recover got n=%0d data=%0h want 1/8", got_bytes.size(), dig.digit_data); end
  endtask

  task automatic test_frame_err();
    logic strobe_before;
    clear_obs();
    strobe_before = exp_strobe;
    send_frame("7", 1'b0, 2 * CPB);
    repeat (CPB) @(negedge clk);
    checks++; if (got_ferr !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", got_ferr); end
    checks++; if (got_bytes.size() !== 0 || dig.digit_strobe !== strobe_before) begin errors++; $display("FAIL ferr_nodecode got bytes=%0d strobe=%0b", got_bytes.size(), dig.digit_strobe); end
    send_frame("3", 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (dig.digit_data !== 4'd3) begin errors++; $display("FAIL ferr_next_data got %0h want 3", dig.digit_data); end
    checks++; if (got_ferr !== exp_ferr) begin errors++; $display("FAIL ferr_total got %0d want %0d", got_ferr, exp_ferr); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_obs();
    b = "9";
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst  = 1'b1;
    line = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dig.digit_data !== 4'd0 || dig.digit_strobe !== 1'b0 || dig.rx_byte !== 8'h00 ||
                  dig.byte_valid !== 1'b0 || dig.frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got d=%0h s=%0b b=%0h want zeros", dig.digit_data, dig.digit_strobe, dig.rx_byte);
    end
    rst = 1'b0;
    exp_strobe = 1'b0;
    exp_digit  = 4'd0;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (got_bytes.size() !== 0 || got_ferr !== 0) begin errors++; $display("FAIL midrst_partial got bytes=%0d ferr=%0d want 0", got_bytes.size(), got_ferr); end
    send_frame("4", 1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (dig.digit_data !== 4'd4) begin errors++; $display("FAIL midrst_data got %0h want 4", dig.digit_data); end
    checks++; if (dig.digit_strobe !== 1'b1) begin errors++; $display("FAIL midrst_strobe got %0b want 1", dig.digit_strobe); end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    bit         good;
    clear_obs();
    for (int n = 0; n < 24; n++) begin
      b    = ($urandom_range(0, 1) == 1) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_frame(b, good, CPB);
      repeat (good ? $urandom_range(0, 3) : CPB) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++; if (got_bytes.size() !== exp_bytes.size()) begin errors++; $display("FAIL rand_byte_count got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    else foreach (exp_bytes[i]) begin
      checks++; if (got_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL rand_byte[%0d] got %0h want %0h", i, got_bytes[i], exp_bytes[i]); end
    end
    checks++; if (got_digits.size() !== exp_digits.size()) begin errors++; $display("FAIL rand_digit_count got %0d want %0d", got_digits.size(), exp_digits.size()); end
    else foreach (exp_digits[i]) begin
      checks++; if (got_digits[i] !== exp_digits[i]) begin errors++; $display("FAIL rand_digit[%0d] got %0h want %0h", i, got_digits[i], exp_digits[i]); end
    end
    checks++; if (got_ferr !== exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d want %0d", got_ferr, exp_ferr); end
    checks++; if (dig.digit_strobe !== exp_strobe || dig.digit_data !== exp_digit) begin
      errors++; $display("FAIL rand_final got %0h/%0b want %0h/%0b", dig.digit_data, dig.digit_strobe, exp_digit, exp_strobe);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_hex_letter();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
